// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor (align / add / normalise-round) with
// valid/ready backpressure. Denormals flush to zero; rounding is nearest-even.
module fp_add_pipe #(
  parameter int EW = 8,
  parameter int MW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          sub_i,
  input  logic          sa_i,
  input  logic [EW-1:0] ea_i,
  input  logic [MW-1:0] ma_i,
  input  logic          sb_i,
  input  logic [EW-1:0] eb_i,
  input  logic [MW-1:0] mb_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          s_o,
  output logic [EW-1:0] e_o,
  output logic [MW-1:0] m_o,
  output logic          of_o,
  output logic          nv_o
);

  localparam int SW = MW + 4;
  localparam int XW = EW + 2;
  localparam logic [EW-1:0] EMAX = '1;
  localparam logic [MW-1:0] QNAN_M = {1'b1, {(MW-1){1'b0}}};
  localparam logic signed [XW-1:0] ONE_X = 1;
  localparam logic signed [XW-1:0] EMAX_X = {2'b00, EMAX};

  typedef struct packed {
    logic          valid;
    logic          sign;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          nv;
  } specT;

  function automatic int lzc(input logic [SW-1:0] v);
    lzc = SW;
    for (int i = 0; i < SW; i++) begin
      if (v[i]) lzc = SW - 1 - i;
    end
  endfunction

  logic          s1Valid_q, s2Valid_q, s3Valid_q;
  logic          free1, free2, free3;

  logic          s1Sign_d, s1Sign_q;
  logic [EW-1:0] s1Exp_d, s1Exp_q;
  logic [SW-1:0] s1SigA_d, s1SigA_q;
  logic [SW-1:0] s1SigB_d, s1SigB_q;
  logic          s1EffSub_d, s1EffSub_q;
  specT          s1Spec_d, s1Spec_q;

  logic          s2Sign_q;
  logic [EW-1:0] s2Exp_q;
  logic [SW:0]   s2Sum_d, s2Sum_q;
  specT          s2Spec_q;

  logic          s3Sign_d, s3Sign_q;
  logic [EW-1:0] s3Exp_d, s3Exp_q;
  logic [MW-1:0] s3Man_d, s3Man_q;
  logic          s3Of_d, s3Of_q;
  logic          s3Nv_d, s3Nv_q;

  // A stage may take new data when it is empty or its contents move on this cycle.
  always_comb begin
    free3   = !s3Valid_q || ready_i;
    free2   = !s2Valid_q || free3;
    free1   = !s1Valid_q || free2;
    ready_o = free1;
  end

  // Stage 1: classify operands, order by magnitude and align the smaller one.
  logic                 aZero, bZero, aInf, bInf, aNan, bNan, sbEff, swap;
  logic [EW+MW-1:0]     keyA, keyB;
  logic                 bigS, bigZ, smlZ;
  logic [EW-1:0]        bigE, smlE, expDiff, shAmt;
  logic [MW-1:0]        bigM, smlM;
  logic [SW-1:0]        sigSml;
  logic [2*SW-1:0]      wide;

  always_comb begin
    aZero  = (ea_i == '0);
    bZero  = (eb_i == '0);
    aInf   = (ea_i == EMAX) && (ma_i == '0);
    bInf   = (eb_i == EMAX) && (mb_i == '0);
    aNan   = (ea_i == EMAX) && (ma_i != '0);
    bNan   = (eb_i == EMAX) && (mb_i != '0);
    sbEff  = sb_i ^ sub_i;
    keyA   = aZero ? '0 : {ea_i, ma_i};
    keyB   = bZero ? '0 : {eb_i, mb_i};
    swap   = keyB > keyA;

    bigS   = swap ? sbEff : sa_i;
    bigE   = swap ? eb_i  : ea_i;
    bigM   = swap ? mb_i  : ma_i;
    bigZ   = swap ? bZero : aZero;
    smlE   = swap ? ea_i  : eb_i;
    smlM   = swap ? ma_i  : mb_i;
    smlZ   = swap ? aZero : bZero;

    expDiff = bigE - smlE;
    shAmt   = (int'(expDiff) > SW - 1) ? EW'(SW - 1) : expDiff;
    sigSml  = smlZ ? '0 : {1'b1, smlM, 3'b000};
    wide    = {sigSml, {SW{1'b0}}} >> shAmt;

    s1Sign_d   = bigS;
    s1Exp_d    = bigE;
    s1SigA_d   = bigZ ? '0 : {1'b1, bigM, 3'b000};
    s1SigB_d   = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    s1EffSub_d = sa_i ^ sbEff;

    s1Spec_d = '0;
    if (aNan || bNan) begin
      s1Spec_d.valid = 1'b1;
      s1Spec_d.e     = EMAX;
      s1Spec_d.m     = QNAN_M;
    end else if (aInf && bInf && (sa_i != sbEff)) begin
      s1Spec_d.valid = 1'b1;
      s1Spec_d.e     = EMAX;
      s1Spec_d.m     = QNAN_M;
      s1Spec_d.nv    = 1'b1;
    end else if (aInf || bInf) begin
      s1Spec_d.valid = 1'b1;
      s1Spec_d.sign  = aInf ? sa_i : sbEff;
      s1Spec_d.e     = EMAX;
    end else if (aZero && bZero) begin
      // Zero sum of zeros is negative only when both addends are negative.
      s1Spec_d.valid = 1'b1;
      s1Spec_d.sign  = sa_i & sbEff;
    end
  end

  // Stage 2: magnitude add/subtract; ordering guarantees a non-negative result.
  always_comb begin
    if (s1EffSub_q) s2Sum_d = {1'b0, s1SigA_q} - {1'b0, s1SigB_q};
    else            s2Sum_d = {1'b0, s1SigA_q} + {1'b0, s1SigB_q};
  end

  // Stage 3: normalise, round nearest-even, then resolve overflow/underflow/specials.
  logic [SW-1:0]          norm;
  logic signed [XW-1:0]   expAdj, expFin;
  logic                   roundUp;
  logic [MW+1:0]          rounded;
  logic [MW-1:0]          manFin;
  int                     lz;

  always_comb begin
    lz = lzc(s2Sum_q[SW-1:0]);
    if (s2Sum_q[SW]) begin
      norm   = {s2Sum_q[SW:2], s2Sum_q[1] | s2Sum_q[0]};
      expAdj = $signed({2'b00, s2Exp_q}) + ONE_X;
    end else begin
      norm   = s2Sum_q[SW-1:0] << lz;
      expAdj = $signed({2'b00, s2Exp_q}) - XW'(lz);
    end
    roundUp = norm[2] & (norm[3] | norm[1] | norm[0]);
    rounded = {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, roundUp};
    if (rounded[MW+1]) begin
      expFin = expAdj + ONE_X;
      manFin = rounded[MW:1];
    end else begin
      expFin = expAdj;
      manFin = rounded[MW-1:0];
    end

    s3Sign_d = s2Sign_q;
    s3Exp_d  = expFin[EW-1:0];
    s3Man_d  = manFin;
    s3Of_d   = 1'b0;
    s3Nv_d   = 1'b0;
    if (s2Spec_q.valid) begin
      s3Sign_d = s2Spec_q.sign;
      s3Exp_d  = s2Spec_q.e;
      s3Man_d  = s2Spec_q.m;
      s3Nv_d   = s2Spec_q.nv;
    end else if (s2Sum_q == '0) begin
      s3Sign_d = 1'b0;
      s3Exp_d  = '0;
      s3Man_d  = '0;
    end else if (expFin >= EMAX_X) begin
      s3Exp_d  = EMAX;
      s3Man_d  = '0;
      s3Of_d   = 1'b1;
    end else if (expFin < ONE_X) begin
      s3Exp_d  = '0;
      s3Man_d  = '0;
    end
  end

  // Pipeline registers; each stage loads only when it is free and upstream holds data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      s3Valid_q  <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Exp_q    <= '0;
      s1SigA_q   <= '0;
      s1SigB_q   <= '0;
      s1EffSub_q <= 1'b0;
      s1Spec_q   <= '0;
      s2Sign_q   <= 1'b0;
      s2Exp_q    <= '0;
      s2Sum_q    <= '0;
      s2Spec_q   <= '0;
      s3Sign_q   <= 1'b0;
      s3Exp_q    <= '0;
      s3Man_q    <= '0;
      s3Of_q     <= 1'b0;
      s3Nv_q     <= 1'b0;
    end else begin
      if (free1) s1Valid_q <= valid_i;
      if (free1 && valid_i) begin
        s1Sign_q   <= s1Sign_d;
        s1Exp_q    <= s1Exp_d;
        s1SigA_q   <= s1SigA_d;
        s1SigB_q   <= s1SigB_d;
        s1EffSub_q <= s1EffSub_d;
        s1Spec_q   <= s1Spec_d;
      end
      if (free2) s2Valid_q <= s1Valid_q;
      if (free2 && s1Valid_q) begin
        s2Sign_q <= s1Sign_q;
        s2Exp_q  <= s1Exp_q;
        s2Sum_q  <= s2Sum_d;
        s2Spec_q <= s1Spec_q;
      end
      if (free3) s3Valid_q <= s2Valid_q;
      if (free3 && s2Valid_q) begin
        s3Sign_q <= s3Sign_d;
        s3Exp_q  <= s3Exp_d;
        s3Man_q  <= s3Man_d;
        s3Of_q   <= s3Of_d;
        s3Nv_q   <= s3Nv_d;
      end
    end
  end

  assign valid_o = s3Valid_q;
  assign s_o     = s3Sign_q;
  assign e_o     = s3Exp_q;
  assign m_o     = s3Man_q;
  assign of_o    = s3Of_q;
  assign nv_o    = s3Nv_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe at bf16 defaults: the driver queues expected
// results on input transfer, a negedge monitor pops them on output transfer.
module tb_fp_add_pipe;

  logic       clk = 1'b0;
  logic       rst, valid_i, ready_o, sub_i, sa_i, sb_i;
  logic [7:0] ea_i, eb_i, e_o;
  logic [6:0] ma_i, mb_i, m_o;
  logic       valid_o, ready_i, s_o, of_o, nv_o;

  fp_add_pipe #(.EW(8), .MW(7)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .sub_i(sub_i),
    .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i), .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
    .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .e_o(e_o), .m_o(m_o),
    .of_o(of_o), .nv_o(nv_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic        of;
    logic        nv;
  } expT;

  typedef struct packed {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        of;
    logic        nv;
  } vecT;

  expT  sbQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   trackReady = 0;
  bit   sawReadyLow = 0;

  vecT directed [0:16] = '{
    '{1'b1, 16'h3F80, 16'h3F80, 16'h0000, 1'b0, 1'b0},
    '{1'b0, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0, 1'b0},
    '{1'b0, 16'h3F81, 16'h3B80, 16'h3F82, 1'b0, 1'b0},
    '{1'b0, 16'h3F80, 16'h3BC0, 16'h3F81, 1'b0, 1'b0},
    '{1'b0, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0, 1'b1},
    '{1'b0, 16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0, 1'b0},
    '{1'b0, 16'h7F7F, 16'h7F7F, 16'h7F80, 1'b1, 1'b0},
    '{1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0},
    '{1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0},
    '{1'b0, 16'h8000, 16'h3F80, 16'h3F80, 1'b0, 1'b0},
    '{1'b0, 16'h7F80, 16'h3F80, 16'h7F80, 1'b0, 1'b0},
    '{1'b0, 16'hFF80, 16'hFF80, 16'hFF80, 1'b0, 1'b0},
    '{1'b1, 16'h7F80, 16'h7F80, 16'h7FC0, 1'b0, 1'b1},
    '{1'b1, 16'h3F80, 16'hBF80, 16'h4000, 1'b0, 1'b0},
    '{1'b0, 16'h3F80, 16'hBF80, 16'h0000, 1'b0, 1'b0},
    '{1'b0, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0},
    '{1'b0, 16'h4040, 16'hC000, 16'h3F80, 1'b0, 1'b0}
  };

  vecT stream [0:5] = '{
    '{1'b0, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, 1'b0},
    '{1'b0, 16'h4000, 16'h3F80, 16'h4040, 1'b0, 1'b0},
    '{1'b1, 16'h4040, 16'h3F80, 16'h4000, 1'b0, 1'b0},
    '{1'b0, 16'hC000, 16'h3F80, 16'hBF80, 1'b0, 1'b0},
    '{1'b1, 16'h3F80, 16'h3F00, 16'h3F00, 1'b0, 1'b0},
    '{1'b0, 16'h4080, 16'h4080, 16'h4100, 1'b0, 1'b0}
  };

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one operand pair and queues its expected result when the transfer happens.
  task automatic applyStimulus(input vecT v);
    bit sent = 0;
    sub_i = v.sub;
    {sa_i, ea_i, ma_i} = v.a;
    {sb_i, eb_i, mb_i} = v.b;
    valid_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_o) begin
        sbQ.push_back('{r: v.r, of: v.of, nv: v.nv});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sent = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!sent) begin
      checks++;
      errors++;
      $display("[TB] FAIL inputTimeout actual=ready_o_low required=accept");
      valid_i = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout actual=%0d pending required=0", sbQ.size());
    end
  endtask

  // Monitor: pop on every output transfer, and require held outputs to stay put.
  initial begin
    expT        e;
    bit         prevHeld = 0;
    logic [17:0] prevOut = '0;
    forever begin
      @(negedge clk);
      if (trackReady && !ready_o) sawReadyLow = 1;
      if (rst) begin
        prevHeld = 0;
      end else begin
        if (prevHeld)
          checkOutput("stable", {13'd0, valid_o, s_o, e_o, m_o, of_o, nv_o}, {13'd0, 1'b1, prevOut});
        if (valid_o && ready_i) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected actual=%h required=none", {s_o, e_o, m_o});
          end else begin
            e = sbQ.pop_front();
            checkOutput("result", {16'd0, s_o, e_o, m_o}, {16'd0, e.r});
            checkOutput("flags", {30'd0, of_o, nv_o}, {30'd0, e.of, e.nv});
          end
        end
        prevHeld = valid_o && !ready_i;
        prevOut  = {s_o, e_o, m_o, of_o, nv_o};
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sub_i = 1'b0;
    sa_i = 1'b0; ea_i = '0; ma_i = '0; sb_i = 1'b0; eb_i = '0; mb_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", {31'd0, valid_o}, 32'd0);
    checkOutput("rstOut", {14'd0, s_o, e_o, m_o, of_o, nv_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstReady", {31'd0, ready_o}, 32'd1);

    // Latency: the transfer edge loads stage 1, valid_o rises two edges later.
    applyStimulus('{1'b0, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    checkOutput("latEarly", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latOnTime", {31'd0, valid_o}, 32'd1);
    waitDrain();

    foreach (directed[i]) applyStimulus(directed[i]);
    waitDrain();

    trackReady = 1;
    fork
      begin
        foreach (stream[i]) applyStimulus(stream[i]);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    waitDrain();
    trackReady = 0;
    checkOutput("readyDrop", {31'd0, sawReadyLow}, 32'd1);

    // Reset with two operations in flight must discard both.
    applyStimulus('{1'b0, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, 1'b0});
    applyStimulus('{1'b0, 16'h4000, 16'h4000, 16'h4080, 1'b0, 1'b0});
    rst = 1'b1;
    sbQ.delete();
    @(posedge clk);
    #1;
    checkOutput("rstFlush", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("noStale", {31'd0, valid_o}, 32'd0);
    checkOutput("readyAfterRst", {31'd0, ready_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
